// File: rtl/pkt_gen_250.sv
// pkt_gen_250 -- transmit-side Ethernet/IPv4/L4 frame generator on a 512-bit AXIS stream.
//
// Builds runs of frames with configurable addresses, ports and protocol so the
// RX filter chain can be exercised on hardware or in simulation.
//
// Ports
//   axis_aclk, box_rst          clock, asynchronous active-high reset
//   start, stop                 run start pulse (IDLE only), graceful stop level
//   cfg_*                       run configuration, latched when start is accepted
//   m_axis_*                    AXIS master: data/keep/last plus size/src/dst sidebands
//   busy, done, sent_cnt        status: not IDLE, end-of-run pulse, frames sent since reset
//
// Frame byte i sits on tdata[8*(i%64) +: 8] of beat i/64; multi-byte fields are
// big-endian. Payload byte i (i >= 42) carries i[7:0].
module pkt_gen_250 #(
  parameter int          DATA_WIDTH = 512,
  parameter int          KEEP_WIDTH = 64,
  parameter logic [47:0] DST_MAC    = 48'h02_00_00_00_00_02,
  parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01
) (
  input  logic                  axis_aclk,
  input  logic                  box_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [15:0]           cfg_pkt_count,
  input  logic [15:0]           cfg_pkt_len,
  input  logic [7:0]            cfg_ifg,
  input  logic [31:0]           cfg_ip_src,
  input  logic [31:0]           cfg_ip_dst,
  input  logic [15:0]           cfg_l4_src,
  input  logic [15:0]           cfg_l4_dst,
  input  logic [7:0]            cfg_ip_proto,
  input  logic [15:0]           cfg_tuser_src,
  input  logic [15:0]           cfg_tuser_dst,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_axis_tuser_size,
  output logic [15:0]           m_axis_tuser_src,
  output logic [15:0]           m_axis_tuser_dst,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           sent_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [KEEP_WIDTH-1:0] ONE_K = KEEP_WIDTH'(1);

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    if (len < 16'd64)        return 16'd64;
    else if (len > 16'd9600) return 16'd9600;
    else                     return len;
  endfunction

  // Latched run configuration
  logic [15:0] len_q, count_q, l4_src_q, l4_dst_q, tsrc_q, tdst_q;
  logic [31:0] ip_src_q, ip_dst_q;
  logic [7:0]  ifg_q, proto_q;

  // Control state
  state_t      state, state_nxt;
  logic [7:0]  beat, beat_nxt;
  logic [15:0] seq, seq_nxt;
  logic [7:0]  gap, gap_nxt;
  logic        load, vld_nxt, done_nxt, sent_inc;

  // Next-beat content
  logic [335:0]           hdr;
  logic [DATA_WIDTH-1:0]  data_nxt;
  logic [KEEP_WIDTH-1:0]  keep_nxt, keep_last;
  logic                   last_nxt;
  logic [7:0]             last_beat;

  logic hs;
  assign hs        = m_axis_tvalid & m_axis_tready;
  // (L-1)/64 is the index of the final beat; L is never below 64.
  assign last_beat = 8'((len_q - 16'd1) >> 6);

  always_ff @(posedge axis_aclk) begin
    if (state == IDLE && start) begin
      len_q    <= clamp_len(cfg_pkt_len);
      count_q  <= cfg_pkt_count;
      ifg_q    <= cfg_ifg;
      ip_src_q <= cfg_ip_src;
      ip_dst_q <= cfg_ip_dst;
      l4_src_q <= cfg_l4_src;
      l4_dst_q <= cfg_l4_dst;
      proto_q  <= cfg_ip_proto;
      tsrc_q   <= cfg_tuser_src;
      tdst_q   <= cfg_tuser_dst;
    end
  end

  // State register
  always_ff @(posedge axis_aclk or posedge box_rst) begin
    if (box_rst) begin
      state    <= IDLE;
      beat     <= '0;
      seq      <= '0;
      gap      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sent_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      seq      <= seq_nxt;
      gap      <= gap_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
      sent_cnt <= sent_cnt + 32'(sent_inc);
    end
  end

  // Next-state logic. Config is latched on the start edge, so the first beat
  // is loaded one cycle later from the latched values (SEND with tvalid low).
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    seq_nxt   = seq;
    gap_nxt   = gap;
    load      = 1'b0;
    vld_nxt   = m_axis_tvalid;
    done_nxt  = 1'b0;
    sent_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_pkt_count != 16'd0) begin
            state_nxt = SEND;
            beat_nxt  = '0;
            seq_nxt   = '0;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      SEND: begin
        if (!m_axis_tvalid) begin
          load    = 1'b1;
          vld_nxt = 1'b1;
        end else if (hs) begin
          if (m_axis_tlast) begin
            sent_inc = 1'b1;
            seq_nxt  = seq + 16'd1;
            beat_nxt = '0;
            if ((seq + 16'd1) == count_q || stop) begin
              state_nxt = IDLE;
              vld_nxt   = 1'b0;
              done_nxt  = 1'b1;
            end else if (ifg_q == 8'd0) begin
              load = 1'b1;
            end else begin
              state_nxt = GAP;
              gap_nxt   = ifg_q;
              vld_nxt   = 1'b0;
            end
          end else begin
            beat_nxt = beat + 8'd1;
            load     = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (gap == 8'd1) begin
          // Load beat 0 here so the idle time is exactly ifg cycles.
          state_nxt = SEND;
          load      = 1'b1;
          vld_nxt   = 1'b1;
        end else begin
          gap_nxt = gap - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: content of the beat that will be presented next
  always_comb begin
    hdr = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, len_q - 16'd14, seq_nxt,
           16'h4000, 8'h40, proto_q, 16'h0000, ip_src_q, ip_dst_q,
           l4_src_q, l4_dst_q, len_q - 16'd34, 16'h0000};
    data_nxt = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      if (beat_nxt == 8'd0 && j < 42)
        data_nxt[8*j +: 8] = hdr[335-8*j -: 8];
      else
        data_nxt[8*j +: 8] = {beat_nxt[1:0], 6'(j)};  // (beat*64 + j) mod 256
    end
    keep_last = (len_q[5:0] == 6'd0) ? '1 : ((ONE_K << len_q[5:0]) - ONE_K);
    last_nxt  = (beat_nxt == last_beat);
    keep_nxt  = last_nxt ? keep_last : '1;
  end

  // AXIS output registers; content only changes on load, so it stays stable
  // while a beat is stalled.
  always_ff @(posedge axis_aclk or posedge box_rst) begin
    if (box_rst) begin
      m_axis_tvalid     <= 1'b0;
      m_axis_tdata      <= '0;
      m_axis_tkeep      <= '0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser_size <= '0;
      m_axis_tuser_src  <= '0;
      m_axis_tuser_dst  <= '0;
    end else begin
      m_axis_tvalid <= vld_nxt;
      if (load) begin
        m_axis_tdata      <= data_nxt;
        m_axis_tkeep      <= keep_nxt;
        m_axis_tlast      <= last_nxt;
        m_axis_tuser_size <= len_q;
        m_axis_tuser_src  <= tsrc_q;
        m_axis_tuser_dst  <= tdst_q;
      end
    end
  end

endmodule
